// File: rtl/conv2d_axis_pkg.sv
// Shared types, default frame geometry and the border test for the conv2D
// AXI-Stream transmitter.
package conv2d_axis_pkg;

  typedef enum logic [2:0] {IDLE, KERNEL, GAP, IMAGE, DONE} tx_state_e;

  localparam int DEF_KERNEL_N = 9;
  localparam int DEF_IMG_H    = 2;
  localparam int DEF_IMG_W    = 5;
  localparam int DEF_PAD      = 1;

  localparam int PH        = DEF_IMG_H + 2 * DEF_PAD;
  localparam int PW        = DEF_IMG_W + 2 * DEF_PAD;
  localparam int IMG_BEATS = PH * PW;
  localparam int BUF_DEPTH = DEF_KERNEL_N + DEF_IMG_H * DEF_IMG_W;

  // True when (r, c) of the padded frame falls in the zero border.
  function automatic logic is_pad(input int r, input int c,
                                  input int ph = PH, input int pw = PW,
                                  input int pad = DEF_PAD);
    return (r < pad) || (r >= ph - pad) || (c < pad) || (c >= pw - pad);
  endfunction

endpackage

// File: rtl/conv2d_axis_tx_if.sv
// AXI-Stream beat channel between the transmitter and the conv2D slave port.
interface conv2d_axis_tx_if #(
  parameter int DATA_W = 16
);
  logic                  TVALID;
  logic [DATA_W-1:0]     TDATA;
  logic [DATA_W/8-1:0]   TKEEP;
  logic                  TLAST;
  logic                  TREADY;

  modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/conv2d_pad_addr_gen.sv
// Walks the zero-padded frame column-major (row fastest) and reports the
// border flag, final-beat flag and buffer address of the current position.
module conv2d_pad_addr_gen
  import conv2d_axis_pkg::*;
#(
  parameter int KERNEL_N = DEF_KERNEL_N,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int PAD      = DEF_PAD,
  parameter int AW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic          pad,
  output logic          last,
  output logic [AW-1:0] addr
);

  localparam int FH = IMG_H + 2 * PAD;
  localparam int FW = IMG_W + 2 * PAD;
  localparam int RW = (FH > 1) ? $clog2(FH) : 1;
  localparam int CW = (FW > 1) ? $clog2(FW) : 1;

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  int            img_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (advance) begin
      if (row_q == RW'(FH - 1)) begin
        row_q <= '0;
        col_q <= (col_q == CW'(FW - 1)) ? '0 : col_q + 1'b1;
      end else begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  always_comb begin
    img_idx = KERNEL_N + (int'(row_q) - PAD) * IMG_W + (int'(col_q) - PAD);
    pad     = is_pad(int'(row_q), int'(col_q), FH, FW, PAD);
    last    = (row_q == RW'(FH - 1)) && (col_q == CW'(FW - 1));
    addr    = pad ? '0 : AW'(img_idx);
  end

endmodule

// File: rtl/conv2d_axis_tx.sv
// Buffers one 3x3 kernel and one feature map, then streams a kernel packet
// and a zero-padded column-major image packet over AXI-Stream.
module conv2d_axis_tx
  import conv2d_axis_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int KERNEL_N   = DEF_KERNEL_N,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int PAD        = DEF_PAD,
  parameter int GAP_CYCLES = 1
) (
  input  logic                                       M_AXIS_ACLK,
  input  logic                                       M_AXIS_ARESET,
  input  logic                                       wr_en,
  input  logic [$clog2(KERNEL_N+IMG_H*IMG_W)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]                          wr_data,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  conv2d_axis_tx_if.master                           m_axis
);

  localparam int AW    = $clog2(KERNEL_N + IMG_H * IMG_W);
  localparam int BUF_N = KERNEL_N + IMG_H * IMG_W;
  localparam int KW    = (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [DATA_W-1:0] mem_q [BUF_N];

  tx_state_e         state_q, state_n;
  logic              tvalid_q, tvalid_n, tlast_q, tlast_n;
  logic              busy_q, busy_n, done_q, done_n;
  logic [DATA_W-1:0] tdata_q, tdata_n;
  logic [KW-1:0]     kidx_q, kidx_n, kidx_inc;
  logic [GW-1:0]     gap_q, gap_n;
  logic              adv, pix_pad, pix_last, xfer, kidx_end;
  logic [AW-1:0]     pix_addr;
  logic [DATA_W-1:0] kern_data, pix_data;

  conv2d_pad_addr_gen #(
    .KERNEL_N (KERNEL_N),
    .IMG_H    (IMG_H),
    .IMG_W    (IMG_W),
    .PAD      (PAD),
    .AW       (AW)
  ) u_addr (
    .clk     (M_AXIS_ACLK),
    .rst     (M_AXIS_ARESET),
    .advance (adv),
    .pad     (pix_pad),
    .last    (pix_last),
    .addr    (pix_addr)
  );

  // Writes are frozen while streaming so the buffer matches what is sent.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_en && !busy_q && (int'(wr_addr) < BUF_N))
      mem_q[wr_addr] <= wr_data;
  end

  assign xfer      = tvalid_q && m_axis.TREADY;
  assign kidx_end  = (kidx_q == KW'(KERNEL_N - 1));
  assign kidx_inc  = kidx_end ? '0 : kidx_q + 1'b1;
  assign kern_data = mem_q[AW'(kidx_q)];
  assign pix_data  = pix_pad ? '0 : mem_q[pix_addr];

  // Next beat is staged from buffer/counters; TREADY only steers the load.
  always_comb begin
    state_n  = state_q;
    tvalid_n = tvalid_q;
    tdata_n  = tdata_q;
    tlast_n  = tlast_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    kidx_n   = kidx_q;
    gap_n    = gap_q;
    adv      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n  = KERNEL;
          busy_n   = 1'b1;
          tvalid_n = 1'b1;
          tdata_n  = kern_data;
          tlast_n  = kidx_end;
          kidx_n   = kidx_inc;
        end
      end
      KERNEL: begin
        if (xfer) begin
          if (!tlast_q) begin
            tdata_n = kern_data;
            tlast_n = kidx_end;
            kidx_n  = kidx_inc;
          end else if (GAP_CYCLES == 0) begin
            state_n  = IMAGE;
            tdata_n  = pix_data;
            tlast_n  = pix_last;
            adv      = 1'b1;
          end else begin
            state_n  = GAP;
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            tdata_n  = '0;
            gap_n    = '0;
          end
        end
      end
      GAP: begin
        if (int'(gap_q) == GAP_CYCLES - 1) begin
          state_n  = IMAGE;
          tvalid_n = 1'b1;
          tdata_n  = pix_data;
          tlast_n  = pix_last;
          adv      = 1'b1;
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end
      IMAGE: begin
        if (xfer) begin
          if (tlast_q) begin
            state_n  = DONE;
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            tdata_n  = '0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else begin
            tdata_n = pix_data;
            tlast_n = pix_last;
            adv     = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kidx_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_n;
      tvalid_q <= tvalid_n;
      tdata_q  <= tdata_n;
      tlast_q  <= tlast_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      kidx_q   <= kidx_n;
      gap_q    <= gap_n;
    end
  end

  assign m_axis.TVALID = tvalid_q;
  assign m_axis.TDATA  = tdata_q;
  assign m_axis.TLAST  = tlast_q;
  assign m_axis.TKEEP  = {(DATA_W/8){tvalid_q}};
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/conv2d_axis_tx.md
Name: conv2d_axis_tx

Overview:
- AXI-Stream transmitter that feeds the conv2D slave port.
- Holds one 3x3 kernel and one feature map in an internal register buffer, loaded through a simple write port.
- On start, emits a kernel packet followed by a zero-padded image packet, with TLAST framing and full TREADY backpressure.
- Replaces bench-driven stimulus and is the upstream source for conv2D in the integrated datapath.

Parameters:
- DATA_W, 16, beat width; TKEEP width is DATA_W/8.
- KERNEL_N, 9, kernel words per kernel packet.
- IMG_H, 2, unpadded image rows.
- IMG_W, 5, unpadded image columns.
- PAD, 1, zero border width on all four sides.
- GAP_CYCLES, 1, idle cycles (TVALID=0) between the kernel packet and the image packet.

Ports:
- M_AXIS_ACLK  in  1  sole clock.
- M_AXIS_ARESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  clog2(KERNEL_N+IMG_H*IMG_W)  buffer address; 0..KERNEL_N-1 is kernel, then image in row-major order.
- wr_data  in  DATA_W  write data.
- start  in  1  single-cycle pulse; begins transmission.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last image beat transfers.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TDATA  out  DATA_W  beat data.
- M_AXIS_TKEEP  out  DATA_W/8  all ones while TVALID, else 0.
- M_AXIS_TLAST  out  1  last beat of the current packet.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): state IDLE; TVALID, TLAST, TKEEP, busy and done all 0; TDATA 0; counters 0. The buffer is not cleared.
- States: IDLE -> KERNEL -> GAP -> IMAGE -> DONE -> IDLE.
- IDLE:
  - start=1 is sampled at edge k; TVALID=1 with the kernel word 0 is visible after edge k.
  - In that same edge, wr_en still writes.
- KERNEL:
  - Beat i carries buffer[i], for i = 0..KERNEL_N-1.
  - TLAST=1 only on beat KERNEL_N-1.
  - After the last transfer, go to GAP.
- GAP:
  - TVALID=0 for exactly GAP_CYCLES cycles, then go to IMAGE.
  - GAP_CYCLES=0 is legal: the first image beat follows the last kernel beat back-to-back.
- IMAGE:
  - The padded frame is PH=IMG_H+2*PAD rows by PW=IMG_W+2*PAD columns, emitted column-major (row index fastest).
  - Beat value is 0 when the row or column lies in the border.
  - Otherwise the value is buffer[KERNEL_N + (r-PAD)*IMG_W + (c-PAD)].
  - TLAST=1 only on beat PH*PW-1.
- DONE:
  - TVALID=0, done=1 and busy=0 for one cycle, then IDLE.
- AXIS rules:
  - A transfer occurs on an edge where TVALID and TREADY are both 1.
  - While TVALID=1 and TREADY=0, TDATA, TLAST and TKEEP are held stable.
  - TVALID never deasserts without a transfer.
  - With TREADY held at 1, one beat transfers per cycle with no bubbles inside a packet.
- Outputs are registered. The next beat is precomputed so that back-to-back transfers need no combinational path from TREADY to TDATA. The only path from TREADY is into the next-state logic.
- start while busy: ignored.
- wr_en while busy: ignored, so the buffer stays coherent with the stream.
- Out-of-range wr_addr: ignored.
- Reset mid-packet: output drops immediately and the packet is truncated. The downstream block must be reset together with this one.
- Counters: kernel index, row and column each wrap at their bound. There is no overflow path.

Decomposition:
- Package conv2d_axis_pkg holds:
  - state enum tx_state_e (IDLE, KERNEL, GAP, IMAGE, DONE);
  - localparams PH, PW, IMG_BEATS=PH*PW, BUF_DEPTH=KERNEL_N+IMG_H*IMG_W;
  - function is_pad(r, c).
- One natural sub-module, conv2d_pad_addr_gen: counts row and column of the padded frame column-major, asserts its pad flag, last flag and buffer address, and advances on an advance strobe.
- The FSM, buffer and output register stay in the top module.

Test Plan:
- Kernel only: load 1..9, image all zero, TREADY=1, start -> 9 kernel beats 1..9 with TLAST on 9, then TVALID=0 for 1 cycle. Image packet is 28 beats of 0 with TLAST on beat 28, then a done pulse.
- Full frame: image rows {1,2,3,4,5} and {6,7,8,9,10} -> image stream is 0,0,0,0, then 0,1,6,0 for each column through 0,5,10,0, then 0,0,0,0. That is 28 beats with TLAST on the last.
- Backpressure: drive TREADY as 1,0,0,1 repeating through both packets -> identical beat sequence. TDATA and TLAST are unchanged while stalled, and TVALID is never dropped before a transfer.
- start and wr_en while busy: pulse start and write addr 0 = 99 during the IMAGE state -> the current stream is unaffected and no second run occurs. A fresh start afterwards still emits kernel beat 0 = 1.
- Reset mid-packet: assert M_AXIS_ARESET asynchronously at image beat 10 -> TVALID, TLAST, busy and done are 0 immediately. After release and start, the complete sequence repeats from kernel beat 1.
- GAP_CYCLES=0, TREADY=1 -> image beat 1 is accepted on the edge after kernel beat 9: 37 consecutive valid cycles in total.
